// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative line cache.
package cache_pkg;

    // Default geometry: 4-bit words, 16 sets, 16-word lines, 2 ways, 16-bit word address
    localparam int unsigned DWIDTH_DEF           = 4;
    localparam int unsigned CACHE_WIDTH_BITS_DEF = 4;
    localparam int unsigned BLOCK_WIDTH_BITS_DEF = 4;
    localparam int unsigned WAYS_WIDTH_BITS_DEF  = 1;
    localparam int unsigned ADDR_IN_WIDTH_DEF    = 16;

    // Address split: tag | set index | word offset
    function automatic int unsigned tag_width(int unsigned addr_w, int unsigned set_bits,
                                              int unsigned block_bits);
        return addr_w - set_bits - block_bits;
    endfunction

    function automatic int unsigned line_width(int unsigned dwidth, int unsigned block_bits);
        return dwidth * (1 << block_bits);
    endfunction

    localparam int unsigned TAG_WIDTH_DEF =
        tag_width(ADDR_IN_WIDTH_DEF, CACHE_WIDTH_BITS_DEF, BLOCK_WIDTH_BITS_DEF);
    localparam int unsigned LINE_WIDTH_DEF = line_width(DWIDTH_DEF, BLOCK_WIDTH_BITS_DEF);

    // Tag and line types for the default geometry
    typedef logic [TAG_WIDTH_DEF-1:0]  tag_t;
    typedef logic [LINE_WIDTH_DEF-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

endpackage

// File: rtl/cache_way_lookup.sv
// Tag compare across all ways of one set, plus fill victim choice.
module cache_way_lookup #(
    parameter int unsigned WAYS_WIDTH_BITS = 1,
    parameter int unsigned TAG_W           = 8,
    localparam int unsigned WAYS           = 1 << WAYS_WIDTH_BITS
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS*TAG_W-1:0]      tags,
    input  logic [TAG_W-1:0]           tag,
    input  logic [WAYS_WIDTH_BITS-1:0] rr_ptr,
    output logic                       hit,
    output logic [WAYS_WIDTH_BITS-1:0] hit_way,
    output logic [WAYS_WIDTH_BITS-1:0] victim_way
);

    // Descending scan so the lowest-index match / invalid way is the one that sticks
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = rr_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[w] && (tags[w*TAG_W +: TAG_W] == tag)) begin
                hit     = 1'b1;
                hit_way = WAYS_WIDTH_BITS'(w);
            end
            if (!valid[w]) begin
                victim_way = WAYS_WIDTH_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/cache_block_set_associative.sv
// Set-associative read cache: word requests in, whole-line fetches out.
module cache_block_set_associative
    import cache_pkg::*;
#(
    parameter int unsigned DWIDTH           = DWIDTH_DEF,
    parameter int unsigned CACHE_WIDTH_BITS = CACHE_WIDTH_BITS_DEF,
    parameter int unsigned BLOCK_WIDTH_BITS = BLOCK_WIDTH_BITS_DEF,
    parameter int unsigned WAYS_WIDTH_BITS  = WAYS_WIDTH_BITS_DEF,
    parameter int unsigned ADDR_IN_WIDTH    = ADDR_IN_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       addr_in_valid,
    input  logic [ADDR_IN_WIDTH-1:0]                   addr_in,
    output logic                                       addr_in_ready,
    output logic [DWIDTH-1:0]                          data_out,
    output logic                                       data_out_valid,
    output logic                                       addr_out_valid,
    output logic [ADDR_IN_WIDTH-BLOCK_WIDTH_BITS-1:0]  addr_out,
    input  logic                                       addr_out_ready,
    input  logic                                       data_in_valid,
    input  logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]    data_in,
    input  logic                                       invalidate_all,
    output logic [31:0]                                hit_count,
    output logic [31:0]                                miss_count
);

    localparam int unsigned SETS    = 1 << CACHE_WIDTH_BITS;
    localparam int unsigned WAYS    = 1 << WAYS_WIDTH_BITS;
    localparam int unsigned TAG_W   = tag_width(ADDR_IN_WIDTH, CACHE_WIDTH_BITS, BLOCK_WIDTH_BITS);
    localparam int unsigned LINE_W  = line_width(DWIDTH, BLOCK_WIDTH_BITS);
    localparam int unsigned LADDR_W = ADDR_IN_WIDTH - BLOCK_WIDTH_BITS;

    // Control state
    state_t                      state_q;
    logic [LADDR_W-1:0]          line_addr_q;
    logic                        addr_out_valid_q;
    logic                        flush_pending_q;
    logic [DWIDTH-1:0]           data_out_q;
    logic                        data_out_valid_q;
    logic [31:0]                 hit_count_q;
    logic [31:0]                 miss_count_q;

    // Cache arrays; tags are packed per set so a whole set feeds the lookup at once
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS_WIDTH_BITS-1:0]  rr_q    [SETS];
    logic [WAYS*TAG_W-1:0]       tag_q   [SETS];
    logic [LINE_W-1:0]           data_q  [SETS][WAYS];

    // Address fields
    logic [TAG_W-1:0]            in_tag;
    logic [CACHE_WIDTH_BITS-1:0] in_set;
    logic [BLOCK_WIDTH_BITS-1:0] in_word;
    logic [TAG_W-1:0]            fill_tag;
    logic [CACHE_WIDTH_BITS-1:0] fill_set;
    logic [CACHE_WIDTH_BITS-1:0] lookup_set;

    logic                        hit;
    logic [WAYS_WIDTH_BITS-1:0]  hit_way;
    logic [WAYS_WIDTH_BITS-1:0]  victim_way;
    logic [DWIDTH-1:0]           hit_word;

    logic                        in_idle;
    logic                        accept_hit;
    logic                        start_miss;
    logic                        fill;
    logic                        flush_now;

    assign in_tag   = addr_in[ADDR_IN_WIDTH-1 -: TAG_W];
    assign in_set   = addr_in[BLOCK_WIDTH_BITS +: CACHE_WIDTH_BITS];
    assign in_word  = addr_in[BLOCK_WIDTH_BITS-1:0];
    assign fill_tag = line_addr_q[LADDR_W-1 -: TAG_W];
    assign fill_set = line_addr_q[CACHE_WIDTH_BITS-1:0];

    // Outside IDLE the lookup serves the fill, so it must look at the latched set
    assign lookup_set = (state_q == IDLE) ? in_set : fill_set;

    cache_way_lookup #(
        .WAYS_WIDTH_BITS (WAYS_WIDTH_BITS),
        .TAG_W           (TAG_W)
    ) u_lookup (
        .valid      (valid_q[lookup_set]),
        .tags       (tag_q[lookup_set]),
        .tag        (in_tag),
        .rr_ptr     (rr_q[lookup_set]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    assign hit_word = data_q[in_set][hit_way][in_word*DWIDTH +: DWIDTH];

    // A flush in IDLE takes priority over the request presented that cycle
    assign in_idle    = (state_q == IDLE);
    assign accept_hit = in_idle && addr_in_valid && !invalidate_all && hit;
    assign start_miss = in_idle && addr_in_valid && !invalidate_all && !hit;
    assign fill       = (state_q == WAIT) && data_in_valid;
    assign flush_now  = (in_idle && invalidate_all) ||
                        (fill && (flush_pending_q || invalidate_all));

    // Request/fill FSM with registered outputs and saturating statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            line_addr_q      <= '0;
            addr_out_valid_q <= 1'b0;
            flush_pending_q  <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            hit_count_q      <= '0;
            miss_count_q     <= '0;
        end else begin
            data_out_valid_q <= accept_hit;
            if (accept_hit) begin
                data_out_q <= hit_word;
                if (hit_count_q != '1) begin
                    hit_count_q <= hit_count_q + 32'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_miss) begin
                        line_addr_q      <= addr_in[ADDR_IN_WIDTH-1:BLOCK_WIDTH_BITS];
                        addr_out_valid_q <= 1'b1;
                        state_q          <= REQ;
                        if (miss_count_q != '1) begin
                            miss_count_q <= miss_count_q + 32'd1;
                        end
                    end
                end
                REQ: begin
                    if (invalidate_all) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (addr_out_ready) begin
                        addr_out_valid_q <= 1'b0;
                        state_q          <= WAIT;
                    end
                end
                WAIT: begin
                    if (invalidate_all) begin
                        flush_pending_q <= 1'b1;
                    end
                    // The pending flush is consumed by this fill via flush_now
                    if (data_in_valid) begin
                        flush_pending_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid bits and round-robin pointers; a flush on the fill cycle lands after the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (fill) begin
                valid_q[fill_set][victim_way] <= 1'b1;
                rr_q[fill_set]                <= victim_way + 1'b1;
            end
            if (flush_now) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                end
            end
        end
    end

    // Tag and line storage, qualified by the valid bits so no reset is needed
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_set][victim_way*TAG_W +: TAG_W] <= fill_tag;
            data_q[fill_set][victim_way]               <= data_in;
        end
    end

    assign addr_in_ready  = accept_hit;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign addr_out_valid = addr_out_valid_q;
    assign addr_out       = line_addr_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

endmodule
